// File: rtl/pipe_hazard_fwd.sv
// Hazard unit for a 5-stage in-order pipeline. It keeps shadow copies of the EX/MEM/WB control,
// drives operand forwarding, load-use stalls and branch flushes, and counts stalls and flushes.
module pipe_hazard_fwd #(
    parameter int XLEN   = 32,
    parameter int RAW    = 5,
    parameter int CNTW   = 16,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] ex_opa,
    input  logic [XLEN-1:0] ex_opb,
    input  logic [XLEN-1:0] mem_alu,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [CNTW-1:0] stall_count,
    output logic [CNTW-1:0] flush_count
);

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rd;
        logic           regwrite;
        logic           memread;
    } stg_t;

    typedef struct packed {
        stg_t           c;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic           uses_rs;
        logic           uses_rt;
    } ex_stg_t;

    localparam bit FWD = (FWD_EN != 0);

    ex_stg_t         ex_q, ex_d;
    stg_t            mem_q, mem_d, wb_q, wb_d;
    logic [CNTW-1:0] stall_count_q, stall_count_d;
    logic [CNTW-1:0] flush_count_q, flush_count_d;

    logic ex_src, mem_src, wb_src;
    logic ex_hit, mem_hit;

    // A stage can supply a value only if it really writes a non-zero register.
    assign ex_src  = ex_q.c.valid && ex_q.c.regwrite && (ex_q.c.rd != '0);
    assign mem_src = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
    assign wb_src  = wb_q.valid && wb_q.regwrite && (wb_q.rd != '0);

    assign ex_hit  = ex_src && ((id_uses_rs && id_rs == ex_q.c.rd) ||
                                (id_uses_rt && id_rt == ex_q.c.rd));
    assign mem_hit = mem_src && ((id_uses_rs && id_rs == mem_q.rd) ||
                                 (id_uses_rt && id_rt == mem_q.rd));

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD) begin
            if (ex_q.uses_rs) begin
                if (mem_src && mem_q.rd == ex_q.rs)     fwd_a = 2'b10;
                else if (wb_src && wb_q.rd == ex_q.rs)  fwd_a = 2'b01;
            end
            if (ex_q.uses_rt) begin
                if (mem_src && mem_q.rd == ex_q.rt)     fwd_b = 2'b10;
                else if (wb_src && wb_q.rd == ex_q.rt)  fwd_b = 2'b01;
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        if (FWD) stall = id_valid && ex_hit && ex_q.c.memread;
        else     stall = id_valid && (ex_hit || mem_hit);
        if (branch_taken) stall = 1'b0;
    end

    assign flush_ifid  = branch_taken;
    assign flush_idex  = branch_taken;
    assign flush_exmem = branch_taken;

    always_comb begin
        case (fwd_a)
            2'b10:   ex_a = mem_alu;
            2'b01:   ex_a = wb_data;
            default: ex_a = ex_opa;
        endcase
        case (fwd_b)
            2'b10:   ex_b = mem_alu;
            2'b01:   ex_b = wb_data;
            default: ex_b = ex_opb;
        endcase
    end

    // Bubbles are stored as all-zero entries so stale register fields can never match.
    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !branch_taken) begin
            ex_d.c.valid    = 1'b1;
            ex_d.c.rd       = id_rd;
            ex_d.c.regwrite = id_regwrite;
            ex_d.c.memread  = id_memread;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.uses_rs    = id_uses_rs;
            ex_d.uses_rt    = id_uses_rt;
        end
        mem_d = branch_taken ? '0 : ex_q.c;
        wb_d  = mem_q;

        stall_count_d = stall_count_q;
        if (stall && stall_count_q != '1) stall_count_d = stall_count_q + CNTW'(1);
        flush_count_d = flush_count_q;
        if (branch_taken && flush_count_q != '1) flush_count_d = flush_count_q + CNTW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    // The WB load flag is kept for pipeline visibility only.
    logic unused_wb_memread;
    assign unused_wb_memread = wb_q.memread;

endmodule

// File: tb/tb_pipe_hazard_fwd.sv
// Directed table-driven bench: dut1 uses forwarding defaults, dut2 is the stall-only
// interlock with 2-bit counters to reach saturation quickly.
module tb_pipe_hazard_fwd;

    logic        clk = 1'b0;
    logic        rst1, rst2;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, branch_taken;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] ex_opa, ex_opb, mem_alu, wb_data;

    logic        st1, fi1, fd1, fe1, st2, fi2, fd2, fe2;
    logic [1:0]  fa1, fb1, fa2, fb2;
    logic [31:0] ea1, eb1, ea2, eb2;
    logic [15:0] sc1, fc1;
    logic [1:0]  sc2, fc2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_fwd dut1 (
        .clk(clk), .reset(rst1), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .mem_alu(mem_alu), .wb_data(wb_data),
        .stall(st1), .flush_ifid(fi1), .flush_idex(fd1), .flush_exmem(fe1),
        .fwd_a(fa1), .fwd_b(fb1), .ex_a(ea1), .ex_b(eb1),
        .stall_count(sc1), .flush_count(fc1)
    );

    pipe_hazard_fwd #(.CNTW(2), .FWD_EN(0)) dut2 (
        .clk(clk), .reset(rst2), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .mem_alu(mem_alu), .wb_data(wb_data),
        .stall(st2), .flush_ifid(fi2), .flush_idex(fd2), .flush_exmem(fe2),
        .fwd_a(fa2), .fwd_b(fb2), .ex_a(ea2), .ex_b(eb2),
        .stall_count(sc2), .flush_count(fc2)
    );

    typedef struct {
        logic        v, urs, urt, rw, mr, br;
        logic [4:0]  rs, rt, rd;
        logic        st;
        logic [1:0]  fa, fb;
        logic [31:0] ea, eb;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];

    function automatic vec_t mk(logic v, int rs, int rt, logic urs, logic urt, int rd,
                                logic rw, logic mr, logic br, logic st, logic [1:0] fa,
                                logic [1:0] fb, logic [31:0] ea, logic [31:0] eb,
                                int sc, int fc);
        vec_t r;
        r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt; r.rd = 5'(rd);
        r.rw = rw; r.mr = mr; r.br = br; r.st = st; r.fa = fa; r.fb = fb;
        r.ea = ea; r.eb = eb; r.sc = 16'(sc); r.fc = 16'(fc);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        id_valid = v.v; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_rd = v.rd; id_regwrite = v.rw; id_memread = v.mr; branch_taken = v.br;
    endtask

    task automatic check_dut(int which, vec_t v, string tag);
        if (which == 0) begin
            chk({tag, " stall"}, 32'(st1), 32'(v.st));
            chk({tag, " fwd_a"}, 32'(fa1), 32'(v.fa));
            chk({tag, " fwd_b"}, 32'(fb1), 32'(v.fb));
            chk({tag, " ex_a"}, ea1, v.ea);
            chk({tag, " ex_b"}, eb1, v.eb);
            chk({tag, " flush"}, {29'd0, fi1, fd1, fe1}, {29'd0, {3{v.br}}});
            chk({tag, " stall_count"}, 32'(sc1), 32'(v.sc));
            chk({tag, " flush_count"}, 32'(fc1), 32'(v.fc));
        end else begin
            chk({tag, " stall"}, 32'(st2), 32'(v.st));
            chk({tag, " fwd_a"}, 32'(fa2), 32'(v.fa));
            chk({tag, " fwd_b"}, 32'(fb2), 32'(v.fb));
            chk({tag, " ex_a"}, ea2, v.ea);
            chk({tag, " ex_b"}, eb2, v.eb);
            chk({tag, " flush"}, {29'd0, fi2, fd2, fe2}, {29'd0, {3{v.br}}});
            chk({tag, " stall_count"}, 32'(sc2), 32'(v.sc));
            chk({tag, " flush_count"}, 32'(fc2), 32'(v.fc));
        end
    endtask

    task automatic run(int which);
        int n;
        vec_t v;
        n = (which == 0) ? t1.size() : t2.size();
        for (int i = 0; i < n; i++) begin
            v = (which == 0) ? t1[i] : t2[i];
            @(negedge clk);
            drive(v);
            #1;
            check_dut(which, v, $sformatf("dut%0d row%0d", which + 1, i));
        end
    endtask

    initial begin
        vec_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0);

        // Forwarding unit: ALU-ALU, distance 2, MEM-over-WB priority, r0 writer/reader.
        t1.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(mk(1, 8, 9, 1, 1, 7, 1, 0, 0, 0, 2'b10, 2'b00, 32'h11, 32'h88, 0, 0));
        t1.push_back(mk(1, 11, 4, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(mk(1, 5, 6, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b01, 32'h99, 32'h22, 0, 0));
        t1.push_back(mk(1, 3, 3, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(mk(1, 3, 3, 1, 1, 9, 1, 0, 0, 0, 2'b10, 2'b10, 32'h11, 32'h11, 0, 0));
        t1.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b10, 32'h11, 32'h11, 0, 0));
        t1.push_back(mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(nop); t1.push_back(nop); t1.push_back(nop);
        // Load-use: one stall, then WB forward.
        t1.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t1.push_back(mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 1, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h22, 32'h88, 1, 0));
        // Back-to-back dependent loads, each with its own single stall.
        t1.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 1, 0));
        t1.push_back(mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 1, 0));
        t1.push_back(mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 2, 0));
        t1.push_back(mk(1, 6, 6, 1, 1, 7, 1, 0, 0, 1, 2'b01, 2'b00, 32'h22, 32'h88, 2, 0));
        t1.push_back(mk(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 32'h22, 32'h22, 3, 0));
        // Branch in the same cycle as a load-use hazard: flush wins, EX and MEM bubble.
        t1.push_back(mk(1, 8, 9, 1, 1, 2, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 0));
        t1.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 0));
        t1.push_back(mk(1, 5, 2, 1, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 0));
        t1.push_back(mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 1));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 1));

        // Stall-only interlock: two stalls at distance 1, no forwarding, counter saturation.
        t2.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t2.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        t2.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 1, 0));
        t2.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 2, 0));
        t2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 2, 0));
        t2.push_back(mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 2, 0));
        t2.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 2, 0));
        t2.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 3, 0));
        t2.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 0));
        for (int i = 0; i < 4; i++)
            t2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, i));
        t2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 3));
        t2.push_back(mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 3, 3));
        t2.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00, 32'h99, 32'h88, 3, 3));

        ex_opa = 32'h99; ex_opb = 32'h88; mem_alu = 32'h11; wb_data = 32'h22;
        rst1 = 1'b1; rst2 = 1'b1;
        // Reset with a load-use pattern on ID: nothing may be captured.
        drive(mk(1, 5, 5, 1, 1, 5, 1, 1, 0, 0, 2'b00, 2'b00, 32'h99, 32'h88, 0, 0));
        repeat (3) @(negedge clk);
        #1;
        check_dut(0, nop, "reset");
        check_dut(1, nop, "reset2");

        drive(nop);
        rst1 = 1'b0;
        run(0);

        @(negedge clk);
        drive(nop);
        rst2 = 1'b0;
        run(1);

        // Asynchronous reset while dut2 is stalling with non-zero counters.
        #1 rst2 = 1'b1;
        #1;
        chk("async_reset stall", 32'(st2), 32'd0);
        chk("async_reset stall_count", 32'(sc2), 32'd0);
        chk("async_reset flush_count", 32'(fc2), 32'd0);
        @(negedge clk);
        #1;
        chk("reset_hold stall", 32'(st2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
